// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Drives a 4-digit common-anode 7-segment display by time multiplexing. It
// sits upstream of the hex-to-segment decoder. Each digit is lit for
// REFRESH_DIV cycles and is followed by BLANK_CYCLES cycles with all anodes
// off, which prevents ghosting. A new value is loaded into a pending register
// at any time. It moves to the displayed register only at the frame boundary,
// so a frame never mixes old and new digits.
//
// Parameters
//   REFRESH_DIV  : cycles each digit is lit (>= 2)
//   BLANK_CYCLES : dead cycles between digits (>= 1)
// Ports
//   clk_in     : system clock, rising edge
//   rst        : asynchronous reset, active-low
//   load       : one-cycle strobe, captures data_in/dp_in as pending value
//   data_in    : 16-bit display value, nibble k -> digit k
//   dp_in      : decimal point request per digit, active-high
//   lz_en      : leading-zero suppression enable
//   hex_out    : nibble of the current digit, to the decoder
//   an_out     : digit anodes, active-low, at most one low
//   dp_out     : decimal point segment, active-low
//   frame_done : one-cycle pulse in the commit cycle
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [3:0]  hex_out,
  output logic [3:0]  an_out,
  output logic        dp_out,
  output logic        frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {
    GAP  = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_pend_data;
  logic [3:0]       r_pend_dp;
  logic [15:0]      r_disp_data;
  logic [3:0]       r_disp_dp;
  logic [3:0]       r_an;
  logic [3:0]       r_hex;
  logic             r_dp;
  logic             r_frame_done;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [1:0]       w_idx_next;
  logic             w_commit;
  logic [15:0]      w_pend_data_next;
  logic [3:0]       w_pend_dp_next;
  logic [15:0]      w_disp_data_next;
  logic [3:0]       w_disp_dp_next;
  logic [3:0]       w_disp_nib [4];
  logic [3:0]       w_nib_zero;
  logic [3:0]       w_zero_from;
  logic             w_enter_scan;
  logic             w_suppress;
  logic [3:0]       w_an_next;
  logic [3:0]       w_hex_next;
  logic             w_dp_next;
  logic             w_frame_done_next;

  // Next-state logic for the scan FSM.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_commit     = 1'b0;
    case (r_state)
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_next = SCAN;
          w_cnt_next   = '0;
          w_idx_next   = r_idx + 2'd1;
          // The last blank after digit 3 is the frame boundary.
          w_commit     = (r_idx == 2'd3);
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      SCAN: begin
        if (r_cnt == SCAN_LAST) begin
          w_state_next = GAP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = GAP;
        w_cnt_next   = '0;
      end
    endcase
  end

  // The pending path already holds this cycle's load. Committing it
  // therefore bypasses a load that arrives in the commit cycle.
  assign w_pend_data_next = load ? data_in : r_pend_data;
  assign w_pend_dp_next   = load ? dp_in   : r_pend_dp;
  assign w_disp_data_next = w_commit ? w_pend_data_next : r_disp_data;
  assign w_disp_dp_next   = w_commit ? w_pend_dp_next   : r_disp_dp;

  // Digit k is blank-eligible when nibbles k..3 of the value being
  // displayed are all zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
      assign w_disp_nib[gi]  = w_disp_data_next[gi*4 +: 4];
      assign w_nib_zero[gi]  = (w_disp_nib[gi] == 4'h0);
      assign w_zero_from[gi] = &w_nib_zero[3:gi];
    end
  endgenerate

  assign w_enter_scan = (r_state == GAP) && (w_state_next == SCAN);
  assign w_suppress   = lz_en && (w_idx_next != 2'd0) && w_zero_from[w_idx_next];

  // Registered outputs are computed from next-state values. They therefore
  // line up with the state they describe.
  always_comb begin
    w_an_next  = r_an;
    w_hex_next = r_hex;
    w_dp_next  = r_dp;
    if (w_enter_scan) begin
      w_an_next  = w_suppress ? 4'hF : ~(4'b0001 << w_idx_next);
      w_hex_next = w_disp_nib[w_idx_next];
      w_dp_next  = ~w_disp_dp_next[w_idx_next];
    end else if (w_state_next == GAP) begin
      w_an_next = 4'hF;
    end
    // Assert in the last blank cycle of digit 3. The next edge commits.
    w_frame_done_next = (w_state_next == GAP) && (w_cnt_next == GAP_LAST) &&
                        (w_idx_next == 2'd3);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state      <= GAP;
      r_cnt        <= '0;
      r_idx        <= 2'd3;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_disp_data  <= '0;
      r_disp_dp    <= '0;
      r_an         <= 4'hF;
      r_hex        <= 4'h0;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_idx        <= w_idx_next;
      r_pend_data  <= w_pend_data_next;
      r_pend_dp    <= w_pend_dp_next;
      r_disp_data  <= w_disp_data_next;
      r_disp_dp    <= w_disp_dp_next;
      r_an         <= w_an_next;
      r_hex        <= w_hex_next;
      r_dp         <= w_dp_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  assign an_out     = r_an;
  assign hex_out    = r_hex;
  assign dp_out     = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Directed bench for seg_scan_ctrl with REFRESH_DIV=8 and BLANK_CYCLES=2,
// which gives a 40-cycle frame. Table vectors are loaded in the frame_done
// cycle, so each one also exercises the commit bypass. Hand-written
// sequences cover the first frame after reset, tear-free update and reset
// in mid-scan.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int DP = RD + BC;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  hex_out;
  logic [3:0]  an_out;
  logic        dp_out;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .hex_out    (hex_out),
    .an_out     (an_out),
    .dp_out     (dp_out),
    .frame_done (frame_done)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][3:0] an_e;   // anode pattern per digit slot
    logic [15:0]     hex_e;  // nibble k = expected hex_out in digit k
    logic [3:0]      dpo_e;  // expected dp_out per digit
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The call starts in a frame_done cycle. The task checks the next full
  // frame, one digit slot plus one blank gap per digit, and ends in that
  // frame's frame_done cycle. It can raise load once, after frame step
  // index load_at.
  task automatic check_frame(input logic [3:0][3:0] an_e, input logic [15:0] hex_e,
                             input logic [3:0] dpo_e, input int load_at,
                             input logic [15:0] load_val, input string tag);
    int t;
    t = 0;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < DP; c++) begin
        step();
        load = 1'b0;
        chk({tag, " an"},  {12'h0, an_out},  {12'h0, (c < RD) ? an_e[d] : 4'hF});
        chk({tag, " hex"}, {12'h0, hex_out}, {12'h0, hex_e[d*4 +: 4]});
        chk({tag, " dp"},  {15'h0, dp_out},  {15'h0, dpo_e[d]});
        chk({tag, " fd"},  {15'h0, frame_done}, {15'h0, (d == 3 && c == DP-1)});
        if (t == load_at) begin
          load    = 1'b1;
          data_in = load_val;
          dp_in   = 4'h0;
        end
        t++;
      end
    end
  endtask

  initial begin
    vecs[0] = '{data: 16'h00F0, dp: 4'b0000, lz: 1'b0, an_e: 16'h7BDE, hex_e: 16'h00F0, dpo_e: 4'b1111};
    vecs[1] = '{data: 16'h0050, dp: 4'b0000, lz: 1'b1, an_e: 16'hFFDE, hex_e: 16'h0050, dpo_e: 4'b1111};
    vecs[2] = '{data: 16'h0000, dp: 4'b0000, lz: 1'b1, an_e: 16'hFFFE, hex_e: 16'h0000, dpo_e: 4'b1111};
    vecs[3] = '{data: 16'h8765, dp: 4'b0100, lz: 1'b0, an_e: 16'h7BDE, hex_e: 16'h8765, dpo_e: 4'b1011};
    vecs[4] = '{data: 16'h0305, dp: 4'b0000, lz: 1'b1, an_e: 16'hFBDE, hex_e: 16'h0305, dpo_e: 4'b1111};
    vecs[5] = '{data: 16'h0050, dp: 4'b0000, lz: 1'b0, an_e: 16'h7BDE, hex_e: 16'h0050, dpo_e: 4'b1111};

    rst = 1'b0; load = 1'b0; data_in = '0; dp_in = '0; lz_en = 1'b0;
    step();
    step();
    $display("reset held");
    chk("rst an",  {12'h0, an_out},  16'h000F);
    chk("rst hex", {12'h0, hex_out}, 16'h0000);
    chk("rst dp",  {15'h0, dp_out},  16'h0001);
    chk("rst fd",  {15'h0, frame_done}, 16'h0000);

    // First frame: release reset and load 1234 in cycle 0.
    rst = 1'b1; load = 1'b1; data_in = 16'h1234; dp_in = 4'h0;
    step();
    load = 1'b0;
    $display("first frame 1234");
    chk("first fd", {15'h0, frame_done}, 16'h0001);
    chk("first an", {12'h0, an_out}, 16'h000F);
    check_frame(16'h7BDE, 16'h1234, 4'b1111, -1, 16'h0, "first");

    // Tear-free: load ABCD midway through digit 1 of a 1234 frame.
    $display("tear-free load ABCD mid digit 1");
    check_frame(16'h7BDE, 16'h1234, 4'b1111, 14, 16'hABCD, "tear");
    check_frame(16'h7BDE, 16'hABCD, 4'b1111, -1, 16'h0, "after_tear");

    // Table vectors: each is loaded in the commit cycle (bypass).
    for (int v = 0; v < 6; v++) begin
      $display("vec %0d data=%h dp=%b lz=%b", v, vecs[v].data, vecs[v].dp, vecs[v].lz);
      load = 1'b1; data_in = vecs[v].data; dp_in = vecs[v].dp; lz_en = vecs[v].lz;
      check_frame(vecs[v].an_e, vecs[v].hex_e, vecs[v].dpo_e, -1, 16'h0, $sformatf("vec%0d", v));
    end

    // Reset in mid-scan during digit 2, with a load still pending.
    $display("reset mid-scan");
    load = 1'b1; data_in = 16'h8765; dp_in = 4'b0100; lz_en = 1'b0;
    for (int s = 1; s <= 24; s++) begin
      step();
      load = 1'b0;
      if (s == 12) begin
        load = 1'b1; data_in = 16'h1111; dp_in = 4'hF;
      end
    end
    chk("mid an",  {12'h0, an_out},  16'h000B);
    chk("mid hex", {12'h0, hex_out}, 16'h0007);
    chk("mid dp",  {15'h0, dp_out},  16'h0000);
    #2 rst = 1'b0;
    #1;
    chk("async an",  {12'h0, an_out},  16'h000F);
    chk("async hex", {12'h0, hex_out}, 16'h0000);
    chk("async dp",  {15'h0, dp_out},  16'h0001);
    chk("async fd",  {15'h0, frame_done}, 16'h0000);
    step();
    rst = 1'b1;
    step();
    chk("rel fd", {15'h0, frame_done}, 16'h0001);
    chk("rel an", {12'h0, an_out}, 16'h000F);
    check_frame(16'h7BDE, 16'h0000, 4'b1111, -1, 16'h0, "cleared");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. It sits directly upstream of the hex-to-segment decoder. It holds a 16-bit display value and selects one nibble at a time onto `hex_out`, which feeds the decoder's `data_in`, while driving the matching active-low digit anode. It also provides tear-free frame-boundary updates, inter-digit blanking against ghosting, and optional leading-zero suppression.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit is lit (must be ≥2).
- `BLANK_CYCLES`, default 4: all-anodes-off dead time between digits (must be ≥1).
- `clk_in`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  reset; asynchronous, active-low.
- `load`  input  1  single-cycle strobe; captures `data_in`/`dp_in` into the pending register.
- `data_in`  input  16  display value; nibble k drives digit k, and digit 0 is `[3:0]`.
- `dp_in`  input  4  decimal point request per digit, active-high.
- `lz_en`  input  1  leading-zero suppression enable; sampled every cycle.
- `hex_out`  output  4  nibble for the current digit, to the decoder.
- `an_out`  output  4  digit anodes, active-low, at most one low at any time.
- `dp_out`  output  1  decimal point segment, active-low.
- `frame_done`  output  1  one-cycle pulse at each frame boundary (commit point).

## Operation
- **Registers:**
  - `pend_data[15:0]` and `pend_dp[3:0]` hold the pending value.
  - `disp_data` and `disp_dp` hold the committed value.
  - `idx[1:0]` is the digit index.
  - The state machine uses `cnt`, wide enough for `max(REFRESH_DIV, BLANK_CYCLES)`.
- **FSM states:** `GAP` and `SCAN`.
  - `GAP`: `an_out`=4'hF. `cnt` counts 0..BLANK_CYCLES-1. On the last count, `idx` increments modulo 4 and the state goes to `SCAN` with `cnt`=0.
  - `SCAN`: `an_out` has bit `idx` low, unless the digit is suppressed, in which case `an_out` stays 4'hF. `cnt` counts 0..REFRESH_DIV-1. On the last count, the state goes to `GAP` with `cnt`=0.
- **Load:**
  - When `load`=1, `pend_data`←`data_in` and `pend_dp`←`dp_in`.
  - Back-to-back loads overwrite; the last one wins.
  - `load` is never blocked and has no acknowledge.
- **Commit:**
  - The commit point is the final `GAP` cycle when `idx`=3, i.e. the wrap to 0.
  - At that point `disp_*` ← `pend_*`, and `frame_done`=1 for that cycle.
  - If `load`=1 in the same cycle, the new `data_in`/`dp_in` is committed directly (bypass).
  - The committed value is unchanged for the entire following frame, so no tearing.
- **Leading-zero suppression:** when `lz_en`=1, digit k (k≥1) is suppressed if `disp_data` nibbles k..3 are all zero. Digit 0 is never suppressed. A suppressed digit keeps its `SCAN` slot timing with anodes off.
- **Output updates:**
  - `hex_out` ← `disp_data` nibble[`idx`_next] on the edge entering `SCAN`.
  - On the same edge, `dp_out` ← ~`disp_dp`[`idx`_next].
  - Both hold through the following `GAP`.
  - Suppressed digits still output their nibble.
- **Reset (asynchronous, `rst`=0):**
  - `state`=`GAP`, `cnt`=0, `idx`=3.
  - `pend_*`=0 and `disp_*`=0.
  - `an_out`=4'hF, `hex_out`=4'h0, `dp_out`=1, `frame_done`=0.
  - Reset mid-scan blanks immediately and discards any pending load.

## Timing
- `an_out`, `hex_out`, `dp_out` and `frame_done` are all registered outputs.
- Digit period is REFRESH_DIV+BLANK_CYCLES; frame period is 4×(REFRESH_DIV+BLANK_CYCLES).
- After `rst` deasserts:
  - The first commit and `frame_done` occur in cycle BLANK_CYCLES-1, counting the first active edge as 0.
  - Digit 0 lights on the next edge.
  - A load in cycles 0..BLANK_CYCLES-1 appears in the first frame.
- Load-to-display latency:
  - At most one frame plus one cycle.
  - Exactly 1 cycle when `load` coincides with the commit cycle.
- Anode overlap is impossible: `SCAN` is always preceded by ≥1 `GAP` cycle.
- A change in `lz_en` takes effect at the next `SCAN` entry.

## Test plan
All scenarios use REFRESH_DIV=8 and BLANK_CYCLES=2, giving a 40-cycle frame.
- **Reset/first frame:** release `rst`, then `load` 16'h1234 with `dp_in`=4'b0000 in cycle 0.
  - `frame_done` pulses in cycle 1.
  - Digit 0 is lit with `an_out`=4'b1110 and `hex_out`=4 for 8 cycles, then 2 cycles of 4'hF.
  - Then 4'b1101/3, 4'b1011/2 and 4'b0111/1 follow; `dp_out`=1 throughout.
- **Tear-free update:** `load` 16'hABCD mid-way through digit 1 of a 16'h1234 frame.
  - Digits 2 and 3 still show 2 and 1.
  - The next frame shows D, C, B, A.
- **Commit-cycle bypass:** assert `load` 16'h00F0 exactly on the `frame_done` cycle; the very next `SCAN` shows `hex_out`=0 on digit 0.
- **Leading-zero suppression:** commit 16'h0050 with `lz_en`=1.
  - Digits 2 and 3 keep `an_out`=4'hF for their slots.
  - Digits 0 and 1 show 0 and 5.
  - With value 16'h0000, only digit 0 lights, showing 0.
- **Decimal point:** commit `dp_in`=4'b0100; `dp_out`=0 only during digit 2's `SCAN` and following `GAP`.
- **Reset mid-operation:** assert `rst` during digit 2's `SCAN`.
  - `an_out`=4'hF, `hex_out`=0 and `dp_out`=1 immediately, with no clock.
  - After release, the display is all zeros (`disp_*` cleared).
